add_seq: RTL
============

# add_seq

Multi-cycle sequencer that performs a WIDTH-bit addition by driving one `add2bit` slice two bits per clock, LSB first, with the carry registered between slices. Sits between an operand producer and a result consumer, each with a valid/ready handshake. Trades latency for area: one 2-bit adder serves any even operand width.

## Interface
- `WIDTH`, default 8: operand and result width in bits. Must be even and at least 2.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `in_valid`  in  1: operands on `a`, `b`, `c_in` (and `sub`) are valid.
- `in_ready`  out  1: block can accept operands.
- `a`  in  WIDTH: addend.
- `b`  in  WIDTH: addend or subtrahend.
- `c_in`  in  1: carry into bit 0.
- `sub`  in  1: subtract request. Present only with `ADD_SEQ_SUB_EN`.
- `out_valid`  out  1: `sum` and `c_out` are valid.
- `out_ready`  in  1: consumer takes the result.
- `sum`  out  WIDTH: result.
- `c_out`  out  1: carry out of bit WIDTH-1.
- `busy`  out  1: high in RUN and DONE.

## Operation
- FSM states and transitions:
  - IDLE → RUN on `in_valid && in_ready`.
  - RUN → DONE after the last slice, when `cnt == WIDTH/2-1`.
  - DONE → IDLE on `out_ready`.
- `in_ready` = (state == IDLE). `out_valid` = (state == DONE).
- On accept, latch:
  - `a` and `b` into operand shift registers;
  - `c_in` into the carry register;
  - `cnt` cleared to 0.
- Each RUN cycle:
  - the slice adds `a_sr[1:0]`, `b_sr[1:0]` and the carry register;
  - both operand registers shift right by 2;
  - the 2-bit slice result enters `sum_sr` at the top `[WIDTH-1:WIDTH-2]` while `sum_sr` shifts right by 2;
  - the carry register takes the slice `c_out`;
  - `cnt` increments.
- After WIDTH/2 slices, `sum_sr` holds the full result in place and the carry register holds the final carry.
- Arithmetic: {`c_out`,`sum`} = `a` + `b` + `c_in`, modulo 2^(WIDTH+1). No saturation.
- Inputs are sampled only on the accepting edge. Changes on `a`, `b` or `c_in` during RUN or DONE are ignored.
- In DONE, `sum` and `c_out` hold stable until the cycle in which `out_ready` is high.
- `out_ready` outside DONE has no effect. `in_valid` outside IDLE has no effect; the producer must hold it.
- Reset at any time, including mid-RUN or in DONE:
  - the state goes to IDLE and the operation in flight is discarded;
  - `out_valid`, `sum`, `c_out`, `busy` and `cnt` are 0;
  - `in_ready` is 1 after the reset edge.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `sum`=0, `c_out`=0.
- Latency: `out_valid` rises WIDTH/2 clocks after the accepting edge (4 clocks for WIDTH=8).
- Minimum initiation interval is WIDTH/2+2 clocks: accept, WIDTH/2 RUN cycles, DONE, IDLE. There is no accept in the same cycle as a result handoff.
- `in_ready` is registered: it goes low the cycle after accept and high the cycle after `out_ready` is taken in DONE.
- The slice path is combinational through `add2bit` only. The register-to-register path is one 2-bit add.

## Configuration
- `ADD_SEQ_SUB_EN` defined:
  - the `sub` port exists and is latched on accept;
  - when `sub`=1, every slice receives the inverted `b` bits, and the initial carry is forced to 1 regardless of `c_in`;
  - the result is {`c_out`,`sum`} = `a` + ~`b` + 1, so `c_out`=1 means no borrow.
- Not defined: no `sub` port. The block only adds, with carry-in from `c_in`.

## Structure
- Package `add_seq_pkg` holds:
  - the FSM state enum {IDLE, RUN, DONE};
  - the function giving the counter width, $clog2(WIDTH/2) with a minimum of 1.
- The WIDTH-even check is an elaboration-time assertion in `add_seq`.
- There is one sub-module instance: the existing `add2bit` (ports a, b, c_in, sum, c_out). `add_seq` holds all sequencing, shift registers and carry state.

## Test plan
All cases use WIDTH=8.
- Basic add: 0x5A + 0x3C, `c_in`=0 → `sum`=0x96, `c_out`=0; `out_valid` high exactly 4 clocks after the accept edge.
- Overflow: 0xFF + 0x01, `c_in`=0 → `sum`=0x00, `c_out`=1.
- Carry through every slice: 0xFF + 0x00, `c_in`=1 → `sum`=0x00, `c_out`=1. Separately, 0xAA + 0x55 → 0xFF, `c_out`=0.
- Backpressure:
  - hold `out_ready`=0 for 5 cycles in DONE → `sum` and `c_out` stable, `in_ready`=0, new `in_valid` ignored;
  - on release, IDLE follows and the next operand pair is accepted correctly.
- Mid-operation reset: assert `rst` on the 2nd RUN cycle → next cycle `out_valid`=0, `busy`=0, `in_ready`=1; a following 0x01 + 0x01 gives 0x02.
- With `ADD_SEQ_SUB_EN`:
  - 0x10 − 0x01 → `sum`=0x0F, `c_out`=1;
  - 0x00 − 0x01 → `sum`=0xFF, `c_out`=0.

Source files
------------

// File: rtl/add_seq_pkg.sv
// Shared types and helpers for the add_seq bit-serial (2 bits/clock) adder.
package add_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    // Slice counter width; a single-slice adder still needs one bit.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width / 2);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/add_seq_add2bit.sv
// add2bit: the 2-bit full-adder slice reused by add_seq, one slice per clock.
module add2bit (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       c_in,
    output logic [1:0] sum,
    output logic       c_out
);

    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {2'b00, c_in};

endmodule

// File: rtl/add_seq.sv
// Multi-cycle WIDTH-bit adder: one add2bit slice, LSB first, carry held in a flop.
// Define ADD_SEQ_SUB_EN to add the `sub` port (a + ~b + 1 when sub=1).
module add_seq
    import add_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef ADD_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH / 2 - 1);

    if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_width_chk
        $error("add_seq: WIDTH must be even and at least 2");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             carry_q, carry_d;

    logic [1:0] b_slice;
    logic [1:0] slice_sum;
    logic       slice_co;
    logic       carry_init;

`ifdef ADD_SEQ_SUB_EN
    logic sub_q, sub_d;

    always_comb begin
        sub_d = sub_q;
        if (state_q == IDLE && in_valid) sub_d = sub;
    end

    always_ff @(posedge clk) begin
        if (rst) sub_q <= 1'b0;
        else     sub_q <= sub_d;
    end

    // Two's-complement subtract: invert b per slice, force the initial carry.
    assign b_slice    = sub_q ? ~b_sr_q[1:0] : b_sr_q[1:0];
    assign carry_init = c_in | sub;
`else
    assign b_slice    = b_sr_q[1:0];
    assign carry_init = c_in;
`endif

    add2bit u_add2bit (
        .a     (a_sr_q[1:0]),
        .b     (b_slice),
        .c_in  (carry_q),
        .sum   (slice_sum),
        .c_out (slice_co)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = RUN;
                    a_sr_d   = a;
                    b_sr_d   = b;
                    carry_d  = carry_init;
                    cnt_d    = '0;
                    sum_sr_d = '0;
                end
            end
            RUN: begin
                a_sr_d   = a_sr_q >> 2;
                b_sr_d   = b_sr_q >> 2;
                // Slice bits enter at the top; after WIDTH/2 shifts they sit in place.
                sum_sr_d = (sum_sr_q >> 2) | (WIDTH'(slice_sum) << (WIDTH - 2));
                carry_d  = slice_co;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign sum       = sum_sr_q;
    assign c_out     = carry_q;

endmodule
